// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 decryption path.
//
// Contents:
//   NR          - number of AES-128 rounds (10)
//   state_t     - controller FSM encoding (IDLE/ROUND/FINAL/DONE)
//   INV_SBOX    - inverse S-box table, indexed by the byte value
//   gf_mul      - GF(2^8) multiply, reduction polynomial 0x11B
//   inv_shift_rows, inv_mix_columns - whole-block inverse transforms
//
// Block byte order: FIPS-197 byte 0 sits in [127:120]. Byte n maps to
// row n%4 and column n/4, so the block is stored column by column.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Shift-and-add multiply; the conditional 0x1b fold is the 0x11B reduction.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    // Each column is multiplied by the circulant matrix with first row 0e 0b 0d 09.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(r + 4*c) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = gf_mul(8'h0e, a[r])
                                         ^ gf_mul(8'h0b, a[(r + 1) % 4])
                                         ^ gf_mul(8'h0d, a[(r + 2) % 4])
                                         ^ gf_mul(8'h09, a[(r + 3) % 4]);
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
//
// Ports:
//   st        in  128  current cipher state
//   round_key in  128  round key for this round
//   last      in  1    final round: skip InvMixColumns
//   st_next   out 128  state after InvShiftRows, InvSubBytes, AddRoundKey
//                      and (unless last) InvMixColumns
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] st_next
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;

    assign shifted = inv_shift_rows(st);

    // InvShiftRows and InvSubBytes commute; doing the byte moves first keeps
    // the S-box lookups aligned with their final byte positions.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign subbed[127 - 8*i -: 8] = INV_SBOX[shifted[127 - 8*i -: 8]];
    end

    assign keyed   = subbed ^ round_key;
    assign st_next = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption controller.
//
// Accepts one ciphertext block, applies round key 10, runs nine full inverse
// rounds (keys 9..1) and one final round without InvMixColumns (key 0), then
// holds the plaintext until the consumer takes it. One inverse round per
// clock, no pipelining: accept-to-accept is 12 cycles at best.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The controller holds out_valid and out_block steady until the
// transfer; the upstream holds in_block steady until in_ready is seen.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     in   ciphertext present
//   in_ready     out  high only in IDLE
//   in_block     in   128-bit ciphertext
//   key_idx      out  round-key index for the external key store
//   round_key    in   key store data for key_idx, same cycle
//   out_valid    out  plaintext present (DONE)
//   out_ready    in   consumer accepts plaintext
//   out_block    out  128-bit plaintext (the state register)
//   busy         out  high in ROUND and FINAL
//   fsm_state    out  current FSM state, for observation
module aes_dec_round_ctrl #(
    parameter int NR = 10  // only 10 (AES-128) is supported
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    import aes_pkg::*;

    localparam logic [3:0] KEY_LAST  = 4'(NR);
    localparam logic [3:0] RND_FIRST = 4'(NR - 1);

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   rnd;
    logic [3:0]   rnd_nxt;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic [127:0] round_out;
    logic         last;

    aes_inv_round u_round (
        .st        (st),
        .round_key (round_key),
        .last      (last),
        .st_next   (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= 4'd0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            st    <= st_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        st_nxt    = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_idx   = KEY_LAST;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // The initial AddRoundKey uses key 10, already on key_idx.
                    st_nxt    = in_block ^ round_key;
                    rnd_nxt   = RND_FIRST;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                busy    = 1'b1;
                key_idx = rnd;
                st_nxt  = round_out;
                if (rnd == 4'd1) state_nxt = FINAL;
                else             rnd_nxt   = rnd - 4'd1;
            end
            FINAL: begin
                busy      = 1'b1;
                key_idx   = 4'd0;
                last      = 1'b1;
                st_nxt    = round_out;
                state_nxt = DONE;
            end
            DONE: begin
                // No accept here even if out_ready is high: the next block
                // is taken one cycle later, from IDLE.
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_block = st;
    assign fsm_state = state;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl. The key store and the reference
// model (S-box built from GF inverses, key expansion, forward cipher and a
// straight inverse cipher) live here.
module tb_aes_dec_round_ctrl;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [1:0]   fsm_state;

    always #5 clk = ~clk;

    aes_dec_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- key store model ----------------
    logic [127:0] ks [11];
    assign round_key = (key_idx <= 4'd10) ? ks[key_idx] : 128'h0;

    // ---------------- reference model ----------------
    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box = affine transform of the multiplicative inverse; inverse table by inversion.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [7:0] bt(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] sub(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv ? isbox_t[bt(s, i)] : sbox_t[bt(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shr(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127 - 8*(r + 4*c) -: 8] = bt(s, r + 4*src);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = gm(m[0], bt(s, r + 4*c))
                                         ^ gm(m[1], bt(s, (r + 1) % 4 + 4*c))
                                         ^ gm(m[2], bt(s, (r + 2) % 4 + 4*c))
                                         ^ gm(m[3], bt(s, (r + 3) % 4 + 4*c));
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s = p ^ ks[0];
        for (int r = 1; r < 10; r++) s = mix(shr(sub(s, 0), 0), 0) ^ ks[r];
        return shr(sub(s, 0), 0) ^ ks[10];
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] c);
        logic [127:0] s = c ^ ks[10];
        for (int r = 9; r >= 1; r--) s = mix(sub(shr(s, 1), 1) ^ ks[r], 1);
        return sub(shr(s, 1), 1) ^ ks[0];
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block and follow it through every cycle. Key index and
    // out_valid are checked on each cycle from accept to DONE; the DONE state
    // is then held for 'hold' cycles with a decoy block offered upstream.
    task automatic run_block(input logic [127:0] c, input logic [127:0] p,
                             input int hold, input string tag);
        logic [127:0] exp;
        int budget = 0;
        in_block  = c;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk({tag, "_in_ready_seen"}, 128'(in_ready), 128'd1);
        chk({tag, "_key_idx_accept"}, 128'(key_idx), 128'd10);
        exp_q.push_back(p);
        tick();  // accept edge
        in_valid = 1'b0;
        // After accept edge j: key 9-j for j=0..9, then 10 once DONE (j=10);
        // out_valid first seen 11 edges counting the accept edge.
        for (int j = 0; j <= 10; j++) begin
            chk({tag, "_key_idx"}, 128'(key_idx), (j <= 9) ? 128'(9 - j) : 128'd10);
            chk({tag, "_out_valid"}, 128'(out_valid), (j == 10) ? 128'd1 : 128'd0);
            if (j < 10) begin
                chk({tag, "_busy"}, 128'(busy), 128'd1);
                tick();
            end
        end
        exp = exp_q.pop_front();
        chk({tag, "_plaintext"}, out_block, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_block = ~c;
            tick();
            chk({tag, "_hold_out_valid"}, 128'(out_valid), 128'd1);
            chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
            chk({tag, "_hold_busy"}, 128'(busy), 128'd0);
            chk({tag, "_hold_block"}, out_block, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();  // output handshake edge
        chk({tag, "_post_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_post_in_ready"}, 128'(in_ready), 128'd1);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] c1_ct;
        logic [127:0] c1_pt;
        logic [127:0] p;
        logic [127:0] p2;
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        int acc_cyc [3];
        int idx;
        int n_out;
        int cyc;
        int budget;
        bit acc;

        build_sbox();
        for (int i = 0; i < 11; i++) ks[i] = '0;
        c1_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        c1_pt = 128'h00112233445566778899aabbccddeeff;

        // Reset, with in_valid/out_ready asserted to show reset dominates.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_block = c1_ct;
        tick();
        tick();
        chk("rst_state", 128'(fsm_state), 128'(aes_pkg::IDLE));
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_key_idx", 128'(key_idx), 128'd10);
        chk("rst_out_block", out_block, 128'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // FIPS-197 C.1.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        run_block(c1_ct, c1_pt, 0, "c1");

        // Random keys and plaintexts, ciphertext from the forward model.
        for (int t = 0; t < 3; t++) begin
            expand_key({$urandom, $urandom, $urandom, $urandom});
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(encrypt(p), p, 0, "rand");
        end

        // Backpressure: 20 cycles of out_ready low, then the next block.
        expand_key({$urandom, $urandom, $urandom, $urandom});
        p  = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        run_block(encrypt(p), p, 20, "bp");
        run_block(encrypt(p2), p2, 0, "bp_next");

        // Back-to-back: in_valid and out_ready held high for three blocks.
        for (int i = 0; i < 3; i++) begin
            pts[i] = {$urandom, $urandom, $urandom, $urandom};
            cts[i] = encrypt(pts[i]);
            exp_q.push_back(pts[i]);
            acc_cyc[i] = 0;
        end
        idx = 0; n_out = 0; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_block = cts[0];
        while (n_out < 3 && cyc < 200) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("b2b_plaintext", out_block, exp_q.pop_front());
                n_out++;
            end
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) in_block = cts[idx];
                else         in_valid = 1'b0;
            end
        end
        chk("b2b_outputs", 128'(n_out), 128'd3);
        chk("b2b_gap_0_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
        chk("b2b_gap_1_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd12);
        in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick();

        // Reset while rnd is 5, then a clean C.1 run.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        in_block = c1_ct; in_valid = 1'b1;
        tick();  // accept edge (controller idle)
        in_valid = 1'b0;
        budget = 0;
        while (key_idx !== 4'd5 && budget < 20) begin
            tick();
            budget++;
        end
        chk("mid_key_idx5", 128'(key_idx), 128'd5);
        chk("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 128'(fsm_state), 128'(aes_pkg::IDLE));
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_out_block", out_block, 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_key_idx", 128'(key_idx), 128'd10);
        run_block(c1_ct, c1_pt, 0, "c1_after_rst");

        // All-zero ciphertext with an all-zero key schedule.
        for (int i = 0; i < 11; i++) ks[i] = '0;
        run_block(128'h0, decrypt(128'h0), 0, "zero");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
